// File: rtl/motor_pwm_pkg.sv
// Constants shared by the Motor PWM driver and decoder so both ends agree on the frame format.
package motor_pwm_pkg;

  localparam int FRAME_TICKS = 256;
  localparam int SPEED_W     = 8;
  localparam int CNT_W       = 9;

  localparam logic DIR_PLUS  = 1'b1;
  localparam logic DIR_MINUS = 1'b0;

  // A full-frame count of 256 does not fit the 8-bit speed field; clamp it to 255.
  function automatic logic [SPEED_W-1:0] sat_speed(input logic [CNT_W-1:0] cnt);
    if (cnt[CNT_W-1]) begin
      return '1;
    end
    return cnt[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Divides clk_in down to the PWM tick; shared with the driver so both ends tick identically.
module pwm_tick_prescaler #(
  parameter int CLK_DIV = 50
) (
  input  logic clk_in,
  input  logic reset_n_in,
  output logic tick_out
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick_out = (count == LAST);

endmodule

// File: rtl/motor_pwm_decoder.sv
// Recovers speed and direction from an H-bridge leg pair over a free-running 256-tick window.
// Optional shoot-through detection is enabled by defining MOTOR_FAULT_DETECT_EN.
module motor_pwm_decoder
  import motor_pwm_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic               motor_plus_in,
  input  logic               motor_minus_in,
  output logic [SPEED_W-1:0] speed_out,
  output logic               direction_out,
  output logic               valid_out,
  output logic               fault_out
);

  logic [SYNC_STAGES-1:0] plus_sync, minus_sync;
  logic                   plus_s, minus_s;
  logic                   tick, window_end;
  logic [7:0]             tick_idx;
  logic [CNT_W-1:0]       plus_cnt, minus_cnt;
  logic [CNT_W-1:0]       plus_nxt, minus_nxt;
  logic [SPEED_W-1:0]     speed_res;
  logic                   dir_res;

  pwm_tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .tick_out  (tick)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      plus_sync  <= '0;
      minus_sync <= '0;
    end else begin
      plus_sync  <= {plus_sync[SYNC_STAGES-2:0], motor_plus_in};
      minus_sync <= {minus_sync[SYNC_STAGES-2:0], motor_minus_in};
    end
  end

  assign plus_s     = plus_sync[SYNC_STAGES-1];
  assign minus_s    = minus_sync[SYNC_STAGES-1];
  assign window_end = tick && (tick_idx == 8'd255);

`ifdef MOTOR_FAULT_DETECT_EN
  logic overlap_tick, overlap_seen;

  assign overlap_tick = tick && plus_s && minus_s;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      fault_out    <= 1'b0;
      overlap_seen <= 1'b0;
    end else begin
      if (overlap_tick) begin
        fault_out <= 1'b1;
      end
      if (window_end) begin
        overlap_seen <= 1'b0;
      end else if (overlap_tick) begin
        overlap_seen <= 1'b1;
      end
    end
  end
`else
  assign fault_out = 1'b0;
`endif

  // The closing tick's sample is folded in here so results register on that same edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    plus_nxt  = plus_cnt + CNT_W'(plus_s);
    minus_nxt = minus_cnt + CNT_W'(minus_s);
    speed_res = sat_speed((plus_nxt >= minus_nxt) ? plus_nxt : minus_nxt);
    dir_res   = direction_out;
    if (plus_nxt > minus_nxt) begin
      dir_res = DIR_PLUS;
    end else if (minus_nxt > plus_nxt) begin
      dir_res = DIR_MINUS;
    end
`ifdef MOTOR_FAULT_DETECT_EN
    if (overlap_seen || overlap_tick) begin
      speed_res = '0;
    end
`endif
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      tick_idx      <= '0;
      plus_cnt      <= '0;
      minus_cnt     <= '0;
      speed_out     <= '0;
      direction_out <= 1'b0;
      valid_out     <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (tick) begin
        tick_idx <= tick_idx + 1'b1;
        if (window_end) begin
          plus_cnt      <= '0;
          minus_cnt     <= '0;
          speed_out     <= speed_res;
          direction_out <= dir_res;
          valid_out     <= 1'b1;
        end else begin
          plus_cnt  <= plus_nxt;
          minus_cnt <= minus_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_pwm_decoder.sv
// Scoreboard bench for motor_pwm_decoder driven by a behavioural PWM driver model.
module tb_motor_pwm_decoder;
  import motor_pwm_pkg::*;

  // Short tick keeps the run small; all timing expectations scale with it.
  localparam int CLK_DIV     = 10;
  localparam int SYNC_STAGES = 2;
  localparam int WINDOW      = FRAME_TICKS * CLK_DIV;

`ifdef MOTOR_FAULT_DETECT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic               clk_in = 1'b0;
  logic               reset_n_in = 1'b1;
  logic               motor_plus_in, motor_minus_in;
  logic [SPEED_W-1:0] speed_out;
  logic               direction_out, valid_out, fault_out;

  always #5 clk_in = ~clk_in;

  motor_pwm_decoder #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .motor_plus_in (motor_plus_in),
    .motor_minus_in(motor_minus_in),
    .speed_out     (speed_out),
    .direction_out (direction_out),
    .valid_out     (valid_out),
    .fault_out     (fault_out)
  );

  // Driver model: free-running frame, never reset, so it is unaligned to the decoder window.
  int         gen_div = 0;
  int         ftick   = 0;
  int         cyc     = 0;
  logic [7:0] cmd_speed = 8'd0;
  logic       cmd_dir   = 1'b0;
  logic       ovr_plus  = 1'b0;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (gen_div == CLK_DIV - 1) begin
      gen_div <= 0;
      ftick   <= (ftick + 1) % FRAME_TICKS;
    end else begin
      gen_div <= gen_div + 1;
    end
  end

  assign motor_plus_in  = ovr_plus || (cmd_dir && (ftick < int'(cmd_speed)));
  assign motor_minus_in = !cmd_dir && (ftick < int'(cmd_speed));

  typedef struct {
    string tag;
    bit    chk;
    int    speed;
    bit    dir;
    bit    from_rst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   rel_cyc = 0;
  int   last_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input string tag, input bit chk, input int spd, input bit dir, input bit from_rst);
    exp_t e;
    e.tag = tag; e.chk = chk; e.speed = spd; e.dir = dir; e.from_rst = from_rst;
    sb.push_back(e);
  endtask

  // Monitor: every valid pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    int   base;
    forever begin
      @(negedge clk_in);
      if (reset_n_in === 1'b1 && valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          base = e.from_rst ? rel_cyc : last_cyc;
          check({e.tag, "_gap"}, cyc - base, WINDOW);
          if (e.chk) begin
            check({e.tag, "_speed"}, int'(speed_out), e.speed);
            check({e.tag, "_dir"}, int'(direction_out), int'(e.dir));
          end
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3 * WINDOW) begin
      @(negedge clk_in);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset_n_in = 1'b0;
    #1;
    check("rst_speed", int'(speed_out), 0);
    check("rst_dir", int'(direction_out), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_fault", int'(fault_out), 0);
    repeat (10) @(negedge clk_in);
    reset_n_in = 1'b1;
    rel_cyc = cyc;
  endtask

  initial begin
    bit fault_seen;

    do_reset();
    push("reset_win", 1'b1, 0, 1'b0, 1'b1);
    drain();

    cmd_speed = 8'd25; cmd_dir = 1'b1;
    push("s25_blend", 1'b0, 0, 1'b0, 1'b0);
    push("s25", 1'b1, 25, 1'b1, 1'b0);
    drain();

    cmd_speed = 8'd0;
    push("s0_blend", 1'b0, 0, 1'b0, 1'b0);
    push("s0_hold_dir", 1'b1, 0, 1'b1, 1'b0);
    drain();

    ovr_plus = 1'b1;
    push("sat_blend", 1'b0, 0, 1'b0, 1'b0);
    push("sat", 1'b1, 255, 1'b1, 1'b0);
    drain();

    ovr_plus = 1'b0;
    cmd_speed = 8'd200; cmd_dir = 1'b0;
    push("s200_blend", 1'b0, 0, 1'b0, 1'b0);
    push("s200", 1'b1, 200, 1'b0, 1'b0);
    drain();

    // One-tick plus pulse while the minus leg is high, placed well inside the window.
    push("fault_win", 1'b1, FAULT_EN ? 0 : 200, 1'b0, 1'b0);
    repeat (20 * CLK_DIV) @(negedge clk_in);
    for (int n = 0; n < 2 * WINDOW; n++) begin
      if (ftick >= 10 && ftick <= 180 && gen_div == 0) break;
      @(negedge clk_in);
    end
    fault_seen = 1'b0;
    ovr_plus = 1'b1;
    for (int i = 0; i < CLK_DIV + SYNC_STAGES + 1; i++) begin
      @(negedge clk_in);
      if (i == CLK_DIV - 1) ovr_plus = 1'b0;
      if (fault_out === 1'b1) fault_seen = 1'b1;
    end
    check("fault_latency", int'(fault_seen), int'(FAULT_EN));
    drain();
    check("fault_sticky", int'(fault_out), int'(FAULT_EN));

    push("post_fault", 1'b1, 200, 1'b0, 1'b0);
    drain();
    check("fault_sticky2", int'(fault_out), int'(FAULT_EN));

    repeat (100 * CLK_DIV) @(negedge clk_in);
    do_reset();
    push("mid_rst", 1'b1, 200, 1'b0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
